// File: rtl/decoder_autotest_if.sv
// Bundle between the decoder autotest sequencer and the board side.
// Carries the buttons, the DUT decoder pins and the status outputs.
interface decoder_autotest_if #(
  parameter int N = 3
);
  logic           start;
  logic           abort;
  logic [N-1:0]   dec_in;
  logic [2**N-1:0] dec_out;
  logic           tick;
  logic           busy;
  logic           done;
  logic           pass;
  logic [N:0]     err_cnt;
  logic           fail_valid;
  logic [N-1:0]   fail_vec;

  modport master (
    input  start, abort, dec_out,
    output dec_in, tick, busy, done, pass,
    output err_cnt, fail_valid, fail_vec
  );

  modport slave (
    output start, abort, dec_out,
    input  dec_in, tick, busy, done, pass,
    input  err_cnt, fail_valid, fail_vec
  );
endinterface

// File: rtl/decoder_autotest_sequencer.sv
// Self-running exhaustive tester for an N-to-2^N decoder.
// Each vector gets one APPLY step and one CHECK step of DIV clocks.
module decoder_autotest_sequencer #(
  parameter int N   = 3,
  parameter int DIV = 50000000
) (
  input logic clk,
  input logic rst,
  decoder_autotest_if.master bus
);
  localparam int W  = 2**N;
  localparam int DW = $clog2(DIV);
  localparam logic [DW-1:0] DMAX = DW'(DIV - 1);
  localparam logic [N-1:0]  LAST = {N{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CHECK,
    DONE
  } state_t;

  state_t        st_q, st_n;
  logic [DW-1:0] div_q, div_n;
  logic [N-1:0]  vec_q, vec_n;
  logic [N-1:0]  din_q, din_n;
  logic [N-1:0]  fvec_q, fvec_n;
  logic [N:0]    err_q, err_n;
  logic          fv_q, fv_n;
  logic          busy_q, done_q, pass_q;
  logic          run, tick, go, miss;
  logic [W-1:0]  hot;

  assign run  = (st_q == APPLY) || (st_q == CHECK);
  assign tick = run && (div_q == DMAX);
  assign go   = bus.start && !bus.abort;
  assign hot  = W'(1) << vec_q;
  assign miss = bus.dec_out != hot;

  always_comb begin
    st_n   = st_q;
    div_n  = '0;
    vec_n  = vec_q;
    din_n  = din_q;
    err_n  = err_q;
    fv_n   = fv_q;
    fvec_n = fvec_q;
    if (run && !tick)
      div_n = div_q + 1'b1;
    if (bus.abort) begin
      st_n  = IDLE;
      din_n = '0;
      div_n = '0;
    end else begin
      unique case (1'b1)
        (st_q == IDLE) || (st_q == DONE): begin
          if (go) begin
            st_n   = APPLY;
            vec_n  = '0;
            din_n  = '0;
            err_n  = '0;
            fv_n   = 1'b0;
            fvec_n = '0;
          end
        end
        st_q == APPLY: begin
          if (tick)
            st_n = CHECK;
        end
        st_q == CHECK: begin
          if (tick) begin
            if (miss) begin
              err_n = err_q + 1'b1;
              // only the first failing vector is kept
              if (!fv_q) begin
                fv_n   = 1'b1;
                fvec_n = vec_q;
              end
            end
            if (vec_q == LAST) begin
              st_n = DONE;
            end else begin
              vec_n = vec_q + 1'b1;
              din_n = vec_q + 1'b1;
              st_n  = APPLY;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      div_q  <= '0;
      vec_q  <= '0;
      din_q  <= '0;
      err_q  <= '0;
      fv_q   <= 1'b0;
      fvec_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      st_q   <= st_n;
      div_q  <= div_n;
      vec_q  <= vec_n;
      din_q  <= din_n;
      err_q  <= err_n;
      fv_q   <= fv_n;
      fvec_q <= fvec_n;
      busy_q <= (st_n == APPLY) || (st_n == CHECK);
      done_q <= st_n == DONE;
      pass_q <= (st_n == DONE) && (err_n == '0);
    end
  end

  assign bus.dec_in     = din_q;
  assign bus.tick       = tick;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_cnt    = err_q;
  assign bus.fail_valid = fv_q;
  assign bus.fail_vec   = fvec_q;
endmodule

// File: tb/tb_decoder_autotest_sequencer.sv
// Bench for decoder_autotest_sequencer: run-time based reference model,
// fault-injecting decoder stand-in with glitches between check edges.
module tb_decoder_autotest_sequencer;
  localparam int N      = 3;
  localparam int DIV    = 4;
  localparam int W      = 8;
  localparam int RUNLEN = 2 * W * DIV;

  logic clk = 1'b0;
  logic rst;

  decoder_autotest_if #(.N(N)) bus ();

  decoder_autotest_sequencer #(.N(N), .DIV(DIV)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] tab [W];
  logic         glitch_en = 1'b0;
  logic         good_q = 1'b1;
  logic [W-1:0] glitch_val = '0;

  // model: mode 0 idle, 1 running, 2 done; t = clocks since run start
  int mode = 0;
  int t = 0;
  int m_err = 0;
  int m_fv = 0;
  int m_fvec = 0;

  function automatic logic [W-1:0] ideal(int v);
    return W'(1) << v;
  endfunction

  wire chk_edge = (mode == 1) && (t % (2 * DIV) == 2 * DIV - 1);

  always @(negedge clk) begin
    good_q     <= chk_edge || !glitch_en;
    glitch_val <= W'($urandom);
  end

  always_comb begin
    bus.dec_out = good_q ? tab[bus.dec_in] : glitch_val;
  end

  always @(posedge clk or posedge rst) begin
    int v;
    if (rst) begin
      mode = 0; t = 0; m_err = 0; m_fv = 0; m_fvec = 0;
    end else if (bus.abort) begin
      mode = 0;
    end else if (mode != 1 && bus.start) begin
      mode = 1; t = 0; m_err = 0; m_fv = 0; m_fvec = 0;
    end else if (mode == 1) begin
      if (t % (2 * DIV) == 2 * DIV - 1) begin
        v = t / (2 * DIV);
        if (tab[v] !== ideal(v)) begin
          m_err++;
          if (m_fv == 0) begin
            m_fv = 1;
            m_fvec = v;
          end
        end
      end
      if (t == RUNLEN - 1) mode = 2;
      else t++;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int e_din;
    e_din = (mode == 1) ? t / (2 * DIV) : (mode == 2) ? W - 1 : 0;
    chk("m_busy", 32'(bus.busy), 32'(mode == 1));
    chk("m_tick", 32'(bus.tick), 32'((mode == 1) && (t % DIV == DIV - 1)));
    chk("m_dec_in", 32'(bus.dec_in), 32'(e_din));
    chk("m_done", 32'(bus.done), 32'(mode == 2));
    chk("m_pass", 32'(bus.pass), 32'((mode == 2) && (m_err == 0)));
    chk("m_err_cnt", 32'(bus.err_cnt), 32'(m_err));
    chk("m_fail_valid", 32'(bus.fail_valid), 32'(m_fv));
    chk("m_fail_vec", 32'(bus.fail_vec), 32'(m_fvec));
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ideal();
    for (int i = 0; i < W; i++) tab[i] = ideal(i);
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", 32'(bus.done), 32'd1);
  endtask

  task automatic wait_din(int k);
    int n;
    n = 0;
    while ((bus.dec_in !== N'(k) || !bus.busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("din_reached", 32'(bus.dec_in), 32'(k));
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_dec_in"}, 32'(bus.dec_in), 32'd0);
    chk({tag, "_tick"}, 32'(bus.tick), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_pass"}, 32'(bus.pass), 32'd0);
    chk({tag, "_err_cnt"}, 32'(bus.err_cnt), 32'd0);
    chk({tag, "_fail_valid"}, 32'(bus.fail_valid), 32'd0);
    chk({tag, "_fail_vec"}, 32'(bus.fail_vec), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_ideal();
    cyc(3);
    chk_zero("reset");
    rst = 1'b0;
    cyc(2);

    // ideal decoder, exact run length
    start_pulse();
    wait_done(n);
    chk("ideal_len", 32'(n), 32'd64);
    chk("ideal_pass", 32'(bus.pass), 32'd1);
    chk("ideal_err", 32'(bus.err_cnt), 32'd0);
    chk("ideal_fv", 32'(bus.fail_valid), 32'd0);
    chk("ideal_din", 32'(bus.dec_in), 32'd7);
    cyc(3);

    // vector 5 reads as zero
    tab[5] = 8'h00;
    glitch_en = 1'b1;
    start_pulse();
    wait_done(n);
    chk("v5_pass", 32'(bus.pass), 32'd0);
    chk("v5_err", 32'(bus.err_cnt), 32'd1);
    chk("v5_fv", 32'(bus.fail_valid), 32'd1);
    chk("v5_fvec", 32'(bus.fail_vec), 32'd5);

    // outputs 7 and 6 swapped
    set_ideal();
    tab[6] = 8'h80;
    tab[7] = 8'h40;
    start_pulse();
    wait_done(n);
    chk("swap_err", 32'(bus.err_cnt), 32'd2);
    chk("swap_fvec", 32'(bus.fail_vec), 32'd6);

    // abort in APPLY of vector 3 with start held
    set_ideal();
    tab[1] = 8'h03;
    start_pulse();
    wait_din(3);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    chk("abort_din", 32'(bus.dec_in), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_err_kept", 32'(bus.err_cnt), 32'd1);
    chk("abort_fvec_kept", 32'(bus.fail_vec), 32'd1);
    cyc(3);
    chk("abort_hold_busy", 32'(bus.busy), 32'd0);
    bus.abort = 1'b0;
    @(negedge clk);
    chk("rerun_busy", 32'(bus.busy), 32'd1);
    chk("rerun_err", 32'(bus.err_cnt), 32'd0);
    chk("rerun_din", 32'(bus.dec_in), 32'd0);
    wait_done(n);
    chk("held_err", 32'(bus.err_cnt), 32'd1);
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'd0);
    chk("restart_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    cyc(2);

    // asynchronous reset while in CHECK of vector 2
    start_pulse();
    wait_din(2);
    cyc(5);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_no_tick", 32'(bus.tick), 32'd0);
    end

    // randomized fault tables, glitches and aborts
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < W; i++)
        tab[i] = ($urandom % 2 == 0) ? ideal(i) : W'($urandom);
      glitch_en = 1'($urandom);
      start_pulse();
      if ($urandom % 3 == 0) begin
        cyc($urandom_range(1, 60));
        bus.abort = 1'b1;
        cyc(1);
        bus.abort = 1'b0;
        cyc(2);
      end else begin
        wait_done(n);
        chk("rand_len", 32'(n), 32'd64);
        cyc($urandom_range(1, 4));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
